graphics_control: RTL and testbench

- Control FSM directly upstream of the 8x8 block-drawing datapath (load / enable / flash / x_in / y_in / colour_in consumer).
- Accepts one move/draw request per handshake and sequences the datapath through up to two 64-pixel passes:
  - optional erase of the previously drawn block in background colour;
  - draw of the new block.
- Produces the plot strobe aligned to the datapath's registered pixel outputs, for the VGA adapter write-enable.

---
 rtl/graphics_control_pkg.sv | 30 +++
 rtl/graphics_control_pass_counter.sv | 25 ++
 rtl/graphics_control.sv | 153 +++++++++++++++
 tb/tb_graphics_control.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/graphics_control_pkg.sv
// Shared definitions for the block-drawing controller: widths, colours, FSM encoding.
package graphics_control_pkg;

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned C_W = 3;

    localparam int unsigned BLOCK_PIXELS_DEF = 64;

    localparam logic [C_W-1:0] BLACK = 3'b000;
    localparam logic [C_W-1:0] WHITE = 3'b111;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StLoadErase = 3'd1,
        StDrawErase = 3'd2,
        StLoadDraw  = 3'd3,
        StDrawDraw  = 3'd4,
        StDone      = 3'd5
    } gc_state_e;

    function automatic logic is_load_state(input gc_state_e s);
        return (s == StLoadErase) || (s == StLoadDraw);
    endfunction

    function automatic logic is_draw_state(input gc_state_e s);
        return (s == StDrawErase) || (s == StDrawDraw);
    endfunction

endpackage

// File: rtl/graphics_control_pass_counter.sv
// Pixel counter for one drawing pass: clears on LOAD, counts during DRAW, flags the last pixel.
module graphics_control_pass_counter #(
    parameter int unsigned Limit = 64,
    parameter int unsigned Width = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    logic [Width-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == Width'(Limit - 1));

endmodule

// File: rtl/graphics_control.sv
// Sequences the 8x8 block datapath through an optional erase pass and a draw pass per request.
module graphics_control
    import graphics_control_pkg::*;
#(
    parameter int unsigned    BLOCK_PIXELS = BLOCK_PIXELS_DEF,
    parameter logic [C_W-1:0] BG_COLOUR    = BLACK
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [X_W-1:0] req_x,
    input  logic [Y_W-1:0] req_y,
    input  logic [C_W-1:0] req_colour,
    input  logic           req_erase,
    input  logic           req_flash,
    output logic           load,
    output logic           enable,
    output logic           flash,
    output logic [X_W-1:0] x_to_dp,
    output logic [Y_W-1:0] y_to_dp,
    output logic [C_W-1:0] colour_to_dp,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CntW = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;

    gc_state_e r_state;
    gc_state_e w_state_next;

    logic [X_W-1:0] r_req_x;
    logic [Y_W-1:0] r_req_y;
    logic [C_W-1:0] r_req_colour;
    logic           r_req_flash;
    logic [X_W-1:0] r_prev_x;
    logic [Y_W-1:0] r_prev_y;
    logic           r_has_prev;

    logic w_accept;
    logic w_pix_tc;

    assign w_accept = req_valid && (r_state == StIdle);

    graphics_control_pass_counter #(
        .Limit (BLOCK_PIXELS),
        .Width (CntW)
    ) u_pass_counter (
        .clock   (clock),
        .reset   (reset),
        .i_clear (is_load_state(r_state)),
        .i_inc   (is_draw_state(r_state)),
        .o_tc    (w_pix_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Reset also forgets the previous block, so the next erase request draws only.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req_x      <= '0;
            r_req_y      <= '0;
            r_req_colour <= '0;
            r_req_flash  <= 1'b0;
            r_prev_x     <= '0;
            r_prev_y     <= '0;
            r_has_prev   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req_x      <= req_x;
                r_req_y      <= req_y;
                r_req_colour <= req_colour;
                r_req_flash  <= req_flash;
            end
            if (r_state == StDone) begin
                r_prev_x   <= r_req_x;
                r_prev_y   <= r_req_y;
                r_has_prev <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_state_next = (req_erase && r_has_prev) ? StLoadErase : StLoadDraw;
                end
            end
            StLoadErase: w_state_next = StDrawErase;
            StDrawErase: begin
                if (w_pix_tc) begin
                    w_state_next = StLoadDraw;
                end
            end
            StLoadDraw:  w_state_next = StDrawDraw;
            StDrawDraw: begin
                if (w_pix_tc) begin
                    w_state_next = StDone;
                end
            end
            StDone:      w_state_next = StIdle;
            default:     w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        load         = 1'b0;
        enable       = 1'b0;
        flash        = 1'b0;
        plot         = 1'b0;
        x_to_dp      = '0;
        y_to_dp      = '0;
        colour_to_dp = '0;
        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            StLoadErase, StDrawErase: begin
                load         = (r_state == StLoadErase);
                plot         = (r_state == StDrawErase);
                enable       = 1'b1;
                x_to_dp      = r_prev_x;
                y_to_dp      = r_prev_y;
                colour_to_dp = BG_COLOUR;
            end
            StLoadDraw, StDrawDraw: begin
                load         = (r_state == StLoadDraw);
                plot         = (r_state == StDrawDraw);
                enable       = 1'b1;
                flash        = r_req_flash;
                x_to_dp      = r_req_x;
                y_to_dp      = r_req_y;
                colour_to_dp = r_req_colour;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_graphics_control.sv
// Self-checking bench: a per-request expected timeline built from the request rules, compared every cycle.
module tb_graphics_control;

    localparam int unsigned    Pix = 64;
    localparam logic [2:0]     Bg  = 3'b000;
    localparam logic [6:0]     FIdle = 7'b1000000;
    localparam logic [6:0]     FDone = 7'b0110000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_x = '0;
    logic [6:0] req_y = '0;
    logic [2:0] req_colour = '0;
    logic       req_erase = 1'b0;
    logic       req_flash = 1'b0;
    logic       load, enable, flash, plot, busy, done;
    logic [7:0] x_to_dp;
    logic [6:0] y_to_dp;
    logic [2:0] colour_to_dp;

    graphics_control dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_colour   (req_colour),
        .req_erase    (req_erase),
        .req_flash    (req_flash),
        .load         (load),
        .enable       (enable),
        .flash        (flash),
        .x_to_dp      (x_to_dp),
        .y_to_dp      (y_to_dp),
        .colour_to_dp (colour_to_dp),
        .plot         (plot),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Reference model of what the controller remembers between requests.
    bit         m_has_prev = 1'b0;
    logic [7:0] m_px = '0;
    logic [6:0] m_py = '0;
    logic [24:0] exp_q[$];

    logic [24:0] obs;
    assign obs = {req_ready, busy, done, load, enable, flash, plot, x_to_dp, y_to_dp, colour_to_dp};

    // Flag order: ready, busy, done, load, enable, flash, plot.
    function automatic logic [24:0] mk(input logic [6:0] f, input logic [7:0] x,
                                       input logic [6:0] y, input logic [2:0] c);
        return {f, x, y, c};
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
        end
    endtask

    task automatic build(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                         input logic er, input logic fl);
        exp_q.delete();
        if (er && m_has_prev) begin
            exp_q.push_back(mk(7'b0101100, m_px, m_py, Bg));
            repeat (Pix) exp_q.push_back(mk(7'b0100101, m_px, m_py, Bg));
        end
        exp_q.push_back(mk({4'b0101, 1'b1, fl, 1'b0}, x, y, c));
        repeat (Pix) exp_q.push_back(mk({4'b0100, 1'b1, fl, 1'b1}, x, y, c));
        exp_q.push_back(mk(FDone, 8'd0, 7'd0, 3'd0));
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_vec("idle", {7'd0, obs}, {7'd0, mk(FIdle, 8'd0, 7'd0, 3'd0)});
        end
    endtask

    // Present a request in an IDLE cycle and follow its whole timeline; abort_at < 0 disables abort.
    task automatic do_request(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                              input logic er, input logic fl, input bit hold, input int abort_at);
        int plots;
        int exp_plots;
        plots = 0;
        @(negedge clock);
        check_vec("ready_before_accept", {7'd0, obs}, {7'd0, mk(FIdle, 8'd0, 7'd0, 3'd0)});
        req_valid  = 1'b1;
        req_x      = x;
        req_y      = y;
        req_colour = c;
        req_erase  = er;
        req_flash  = fl;
        build(x, y, c, er, fl);
        exp_plots = (er && m_has_prev) ? 2 * Pix : Pix;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            if (hold) begin
                req_x      = 8'($urandom);
                req_y      = 7'($urandom);
                req_colour = 3'($urandom);
                req_erase  = 1'($urandom);
                req_flash  = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            if (plot) plots++;
            check_vec($sformatf("cycle%0d", i + 1), {7'd0, obs}, {7'd0, exp_q[i]});
            if (i == abort_at) begin
                reset     = 1'b1;
                req_valid = 1'b0;
                @(negedge clock);
                check_vec("after_abort", {7'd0, obs}, {7'd0, mk(FIdle, 8'd0, 7'd0, 3'd0)});
                reset      = 1'b0;
                m_has_prev = 1'b0;
                return;
            end
        end
        check_vec("plot_count", plots, exp_plots);
        m_has_prev = 1'b1;
        m_px       = x;
        m_py       = y;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_vec("in_reset", {7'd0, obs}, {7'd0, mk(FIdle, 8'd0, 7'd0, 3'd0)});
        reset = 1'b0;
        idle_cycles(100);

        do_request(8'd10, 7'd20, 3'b100, 1'b1, 1'b0, 1'b0, -1);
        idle_cycles(2);
        do_request(8'd12, 7'd20, 3'b010, 1'b1, 1'b0, 1'b0, -1);
        do_request(8'd30, 7'd40, 3'b101, 1'b1, 1'b1, 1'b0, -1);
        do_request(8'd31, 7'd41, 3'b011, 1'b1, 1'b0, 1'b0, 65 + 31);
        do_request(8'd70, 7'd10, 3'b110, 1'b1, 1'b0, 1'b0, -1);
        do_request(8'd50, 7'd60, 3'b011, 1'b0, 1'b0, 1'b0, 31);
        do_request(8'd250, 7'd125, 3'b001, 1'b1, 1'b0, 1'b0, -1);

        for (int k = 0; k < 3; k++) begin
            do_request(8'($urandom), 7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                       1'b1, -1);
        end

        for (int k = 0; k < 8; k++) begin
            idle_cycles(int'($urandom_range(0, 3)));
            do_request(8'($urandom), 7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), -1);
        end
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
